// File: rtl/conv3x3_mc_acc.sv
// rtl/conv3x3_mc_acc.sv - multi-kernel, multi-channel 3x3 convolution with accumulate, bias, ReLU and requantise
module conv3x3_mc_acc #(
  parameter int DATA_WIDTH   = 8,
  parameter int KERNEL_WIDTH = 8,
  parameter int KERNEL_NUM   = 4,
  parameter int IN_CH        = 16,
  parameter int BIAS_WIDTH   = 16,
  parameter int ACC_WIDTH    = DATA_WIDTH + KERNEL_WIDTH + 4 + $clog2(IN_CH) + 1,
  parameter int OUT_WIDTH    = 8,
  parameter int OUT_SHIFT    = 8,
  parameter bit RELU_EN      = 1'b1,
  parameter     INI_FILE     = "",
  parameter     BIAS_FILE    = "",
  parameter logic [IN_CH*KERNEL_NUM*9*KERNEL_WIDTH-1:0] WEIGHT_INIT = '0,
  parameter logic [KERNEL_NUM*BIAS_WIDTH-1:0]           BIAS_INIT   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9*DATA_WIDTH-1:0]          data_i,
  input  logic                             data_valid_i,
  input  logic                             sop_i,
  input  logic                             eop_i,
  input  logic                             sof_i,
  input  logic                             eof_i,
  output logic [KERNEL_NUM*OUT_WIDTH-1:0]  data_o,
  output logic                             data_valid_o,
  output logic                             sop_o,
  output logic                             eop_o,
  output logic                             sof_o,
  output logic                             eof_o,
  output logic                             err_o
);

  localparam int PW = DATA_WIDTH + KERNEL_WIDTH;
  localparam int RW = KERNEL_NUM * 9 * KERNEL_WIDTH;
  localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(IN_CH - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Weight ROM words (one per input channel) and per-kernel bias
  logic [RW-1:0]                 w_rom  [IN_CH];
  logic signed [BIAS_WIDTH-1:0]  w_bias [KERNEL_NUM];

  for (genvar c = 0; c < IN_CH; c++) begin : g_rom_c
    assign w_rom[c] = WEIGHT_INIT[c*RW +: RW];
  end

  for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_bias_k
    assign w_bias[k] = $signed(BIAS_INIT[k*BIAS_WIDTH +: BIAS_WIDTH]);
  end

  logic [CW-1:0]          r_ch_cnt;
  logic [3:0]             r_mk_hold;
  logic                   r_err;
  logic                   r1_v, r1_first, r1_last;
  logic [3:0]             r1_mk;
  logic [9*DATA_WIDTH-1:0] r1_data;
  logic [RW-1:0]          r1_wword;
  logic                   r2_v, r2_first, r2_last;
  logic [3:0]             r2_mk;
  logic signed [PW-1:0]   r2_prod [KERNEL_NUM][9];
  logic                   r3_v, r3_first, r3_last;
  logic [3:0]             r3_mk;
  logic signed [ACC_WIDTH-1:0] r3_sum [KERNEL_NUM];
  logic signed [ACC_WIDTH-1:0] r_acc  [KERNEL_NUM];
  logic                   r4_v;
  logic [3:0]             r4_mk;
  logic signed [ACC_WIDTH-1:0] r4_res [KERNEL_NUM];
  logic                   r5_v;
  logic [3:0]             r5_mk;
  logic signed [ACC_WIDTH-1:0] r5_sh  [KERNEL_NUM];
  logic [OUT_WIDTH-1:0]   r_data_o [KERNEL_NUM];
  logic                   r_valid_o;
  logic [3:0]             r_mk_o;

  logic [CW-1:0]          w_ch, w_ch_next;
  logic                   w_resync, w_first, w_last;
  logic [3:0]             w_mk;
  logic signed [ACC_WIDTH-1:0] w_sum      [KERNEL_NUM];
  logic signed [ACC_WIDTH-1:0] w_acc_next [KERNEL_NUM];
  logic signed [ACC_WIDTH-1:0] w_relu     [KERNEL_NUM];
  logic [OUT_WIDTH-1:0]   w_sat [KERNEL_NUM];

  // Effective channel of the incoming beat: a stray sof restarts the pixel at channel 0
  always_comb begin
    w_resync  = sof_i && (r_ch_cnt != '0);
    w_ch      = w_resync ? '0 : r_ch_cnt;
    w_first   = (w_ch == '0);
    w_last    = (w_ch == LAST_CH);
    w_ch_next = w_last ? '0 : w_ch + 1'b1;
    w_mk      = w_first ? {sop_i, eop_i, sof_i, eof_i} : r_mk_hold;
  end

  // Channel counter, error pulse, marker hold and stage-1 operand/ROM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_cnt  <= '0;
      r_mk_hold <= '0;
      r_err     <= 1'b0;
      r1_v      <= 1'b0;
      r1_first  <= 1'b0;
      r1_last   <= 1'b0;
      r1_mk     <= '0;
      r1_data   <= '0;
      r1_wword  <= '0;
    end else begin
      r1_v  <= data_valid_i;
      r_err <= data_valid_i && w_resync;
      if (data_valid_i) begin
        r_ch_cnt  <= w_ch_next;
        r_mk_hold <= w_mk;
        r1_first  <= w_first;
        r1_last   <= w_last;
        r1_mk     <= w_mk;
        r1_data   <= data_i;
        r1_wword  <= w_rom[w_ch];
      end
    end
  end

  // Stage 2: nine signed products per kernel
  always_ff @(posedge clk) begin
    if (reset) begin
      r2_v     <= 1'b0;
      r2_first <= 1'b0;
      r2_last  <= 1'b0;
      r2_mk    <= '0;
    end else begin
      r2_v     <= r1_v;
      r2_first <= r1_first;
      r2_last  <= r1_last;
      r2_mk    <= r1_mk;
      for (int k = 0; k < KERNEL_NUM; k++) begin
        for (int j = 0; j < 9; j++) begin
          r2_prod[k][j] <= $signed(r1_data[j*DATA_WIDTH +: DATA_WIDTH]) *
                           $signed(r1_wword[(k*9+j)*KERNEL_WIDTH +: KERNEL_WIDTH]);
        end
      end
    end
  end

  // Adder tree per kernel, products sign-extended to the accumulator width
  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      w_sum[k] = '0;
      for (int j = 0; j < 9; j++) begin
        w_sum[k] = w_sum[k] + ACC_WIDTH'(r2_prod[k][j]);
      end
    end
  end

  // Stage 3: register the per-beat window sums
  always_ff @(posedge clk) begin
    if (reset) begin
      r3_v     <= 1'b0;
      r3_first <= 1'b0;
      r3_last  <= 1'b0;
      r3_mk    <= '0;
    end else begin
      r3_v     <= r2_v;
      r3_first <= r2_first;
      r3_last  <= r2_last;
      r3_mk    <= r2_mk;
      for (int k = 0; k < KERNEL_NUM; k++) r3_sum[k] <= w_sum[k];
    end
  end

  // Channel-0 beat loads the accumulator, later beats add to it
  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      w_acc_next[k] = r3_first ? r3_sum[k] : r_acc[k] + r3_sum[k];
    end
  end

  // Stage 4: accumulate and, on the last channel, add bias and hand the pixel on
  always_ff @(posedge clk) begin
    if (reset) begin
      r4_v  <= 1'b0;
      r4_mk <= '0;
      for (int k = 0; k < KERNEL_NUM; k++) r_acc[k] <= '0;
    end else begin
      r4_v <= r3_v && r3_last;
      if (r3_v) begin
        for (int k = 0; k < KERNEL_NUM; k++) r_acc[k] <= w_acc_next[k];
      end
      if (r3_v && r3_last) begin
        r4_mk <= r3_mk;
        for (int k = 0; k < KERNEL_NUM; k++) begin
          r4_res[k] <= w_acc_next[k] + ACC_WIDTH'(w_bias[k]);
        end
      end
    end
  end

  // Optional ReLU ahead of the shift
  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      w_relu[k] = (RELU_EN && r4_res[k][ACC_WIDTH-1]) ? '0 : r4_res[k];
    end
  end

  // Stage 5: arithmetic (flooring) shift
  always_ff @(posedge clk) begin
    if (reset) begin
      r5_v  <= 1'b0;
      r5_mk <= '0;
    end else begin
      r5_v <= r4_v;
      if (r4_v) begin
        r5_mk <= r4_mk;
        for (int k = 0; k < KERNEL_NUM; k++) r5_sh[k] <= w_relu[k] >>> OUT_SHIFT;
      end
    end
  end

  // Saturate to the signed output range
  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (r5_sh[k] > SAT_MAX)      w_sat[k] = SAT_MAX[OUT_WIDTH-1:0];
      else if (r5_sh[k] < SAT_MIN) w_sat[k] = SAT_MIN[OUT_WIDTH-1:0];
      else                         w_sat[k] = r5_sh[k][OUT_WIDTH-1:0];
    end
  end

  // Stage 6: output registers; data holds between results, markers only with valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_o <= 1'b0;
      r_mk_o    <= '0;
      for (int k = 0; k < KERNEL_NUM; k++) r_data_o[k] <= '0;
    end else begin
      r_valid_o <= r5_v;
      r_mk_o    <= r5_v ? r5_mk : 4'b0;
      if (r5_v) begin
        for (int k = 0; k < KERNEL_NUM; k++) r_data_o[k] <= w_sat[k];
      end
    end
  end

  for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_out
    assign data_o[k*OUT_WIDTH +: OUT_WIDTH] = r_data_o[k];
  end

  assign data_valid_o = r_valid_o;
  assign {sop_o, eop_o, sof_o, eof_o} = r_mk_o;
  assign err_o = r_err;

endmodule

// File: tb/tb_conv3x3_mc_acc.sv
// tb/tb_conv3x3_mc_acc.sv - self-checking bench for conv3x3_mc_acc
module tb_conv3x3_mc_acc;

  localparam int IN_CH = 4;
  localparam int KN    = 2;
  localparam int RW    = KN * 9 * 8;

  typedef struct {
    int         d0, d1, r0, r1;
    logic [3:0] mk;
    int         cyc;
  } exp_t;

  typedef struct {
    int d[IN_CH];
    int x;
    int e0, e1, r0, r1;
  } vec_t;

  function automatic int wgt(int c, int k, int j);
    return (k == 0) ? 1 : (j - 4) * (c + 1);
  endfunction

  function automatic int bias(int k);
    return (k == 0) ? 0 : 500;
  endfunction

  function automatic logic [IN_CH*RW-1:0] gen_weights();
    logic [IN_CH*RW-1:0] v;
    v = '0;
    for (int c = 0; c < IN_CH; c++)
      for (int k = 0; k < KN; k++)
        for (int j = 0; j < 9; j++)
          v[c*RW + (k*9+j)*8 +: 8] = 8'(wgt(c, k, j));
    return v;
  endfunction

  localparam logic [IN_CH*RW-1:0] W_INIT = gen_weights();
  localparam logic [KN*16-1:0]    B_INIT = {16'd500, 16'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [71:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;
  logic [15:0] data_o_n, data_o_r;
  logic        valid_n, valid_r;
  logic        sop_n, eop_n, sof_n, eof_n, err_n;
  logic        sop_r, eop_r, sof_r, eof_r, err_r;

  conv3x3_mc_acc #(.DATA_WIDTH(8), .KERNEL_WIDTH(8), .KERNEL_NUM(KN), .IN_CH(IN_CH),
    .BIAS_WIDTH(16), .OUT_WIDTH(8), .OUT_SHIFT(3), .RELU_EN(1'b0),
    .WEIGHT_INIT(W_INIT), .BIAS_INIT(B_INIT)) u_dut (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(data_o_n), .data_valid_o(valid_n),
    .sop_o(sop_n), .eop_o(eop_n), .sof_o(sof_n), .eof_o(eof_n), .err_o(err_n));

  conv3x3_mc_acc #(.DATA_WIDTH(8), .KERNEL_WIDTH(8), .KERNEL_NUM(KN), .IN_CH(IN_CH),
    .BIAS_WIDTH(16), .OUT_WIDTH(8), .OUT_SHIFT(3), .RELU_EN(1'b1),
    .WEIGHT_INIT(W_INIT), .BIAS_INIT(B_INIT)) u_relu (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
    .data_o(data_o_r), .data_valid_o(valid_r),
    .sop_o(sop_r), .eop_o(eop_r), .sof_o(sof_r), .eof_o(eof_r), .err_o(err_r));

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_valid = 0;
  int   n_pushed = 0;
  exp_t sb[$];
  int   err_q[$];
  int   pix [IN_CH][9];
  vec_t tab [8];

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int requant(longint a, bit relu);
    longint v;
    v = a;
    if (relu && v < 0) v = 0;
    v = (v >= 0) ? v / 8 : -((-v + 7) / 8);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic exp_t model_pixel(logic [3:0] mk);
    exp_t   e;
    longint acc [KN];
    for (int k = 0; k < KN; k++) begin
      acc[k] = bias(k);
      for (int c = 0; c < IN_CH; c++)
        for (int j = 0; j < 9; j++)
          acc[k] += longint'(pix[c][j] * wgt(c, k, j));
    end
    e.d0 = requant(acc[0], 1'b0);
    e.d1 = requant(acc[1], 1'b0);
    e.r0 = requant(acc[0], 1'b1);
    e.r1 = requant(acc[1], 1'b1);
    e.mk = mk;
    e.cyc = 0;
    return e;
  endfunction

  task automatic idle();
    data_valid_i = 1'b0;
    {sop_i, eop_i, sof_i, eof_i} = 4'b0;
  endtask

  task automatic drive_beat(input int c, input logic [3:0] mk);
    data_valid_i = 1'b1;
    for (int j = 0; j < 9; j++) data_i[j*8 +: 8] = 8'(pix[c][j]);
    {sop_i, eop_i, sof_i, eof_i} = mk;
  endtask

  task automatic rand_pix(input int lo, input int hi);
    for (int c = 0; c < IN_CH; c++)
      for (int j = 0; j < 9; j++)
        pix[c][j] = int'($urandom_range(hi - lo)) + lo;
  endtask

  // One full pixel; the expectation comes from the model or from a table record
  task automatic send_pixel(input logic [3:0] mk, input int gap_max, input bit use_tab,
                            input vec_t tv, input bit exp_err);
    exp_t e;
    for (int c = 0; c < IN_CH; c++) begin
      @(negedge clk);
      if (c == 0) drive_beat(c, mk);
      else drive_beat(c, {1'($urandom), 1'($urandom), 1'b0, 1'($urandom)});
      if (c == 0 && exp_err) err_q.push_back(cyc + 1);
      if (c == IN_CH - 1) begin
        e = model_pixel(mk);
        if (use_tab) begin
          e.d0 = tv.e0; e.d1 = tv.e1; e.r0 = tv.r0; e.r1 = tv.r1;
        end
        e.cyc = cyc + 6;
        sb.push_back(e);
        n_pushed++;
      end else begin
        repeat ($urandom_range(gap_max)) begin
          @(negedge clk);
          idle();
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic send_beats(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_beat(c, 4'b0);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || err_q.size() != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 40, 1);
  endtask

  // Monitor: sampled 1 time unit after every rising edge
  initial begin
    logic [15:0] last_n, last_r;
    exp_t e;
    bit   ee;
    last_n = '0;
    last_r = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        check("rst_data", data_o_n, 0);
        check("rst_data_relu", data_o_r, 0);
        check("rst_valid", {valid_n, valid_r}, 0);
        check("rst_markers", {sop_n, eop_n, sof_n, eof_n, sop_r, eop_r, sof_r, eof_r}, 0);
        check("rst_err", {err_n, err_r}, 0);
        last_n = '0;
        last_r = '0;
      end else begin
        ee = 1'b0;
        if (err_q.size() != 0 && err_q[0] == cyc) begin
          ee = 1'b1;
          void'(err_q.pop_front());
        end
        check("err", err_n, ee);
        check("err_relu", err_r, ee);
        check("valid_relu", valid_r, valid_n);
        if (valid_n) begin
          n_valid++;
          if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check("latency", cyc, e.cyc);
            check("k0", int'($signed(data_o_n[7:0])), e.d0);
            check("k1", int'($signed(data_o_n[15:8])), e.d1);
            check("k0_relu", int'($signed(data_o_r[7:0])), e.r0);
            check("k1_relu", int'($signed(data_o_r[15:8])), e.r1);
            check("markers", {sop_n, eop_n, sof_n, eof_n}, e.mk);
            check("markers_relu", {sop_r, eop_r, sof_r, eof_r}, e.mk);
          end
          last_n = data_o_n;
          last_r = data_o_r;
        end else begin
          check("hold", data_o_n, last_n);
          check("hold_relu", data_o_r, last_r);
          check("idle_markers", {sop_n, eop_n, sof_n, eof_n, sop_r, eop_r, sof_r, eof_r}, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t none;
    int   nv;
    //            d[0..3]                x     e0    e1   r0   r1
    tab[0] = '{d:'{127, 127, 127, 127},  x:0,    e0:127,  e1:62,  r0:127, r1:62};
    tab[1] = '{d:'{-128,-128,-128,-128}, x:0,    e0:-128, e1:62,  r0:0,   r1:62};
    tab[2] = '{d:'{30, 30, 30, 21},      x:1,    e0:125,  e1:62,  r0:125, r1:62};
    tab[3] = '{d:'{-30,-30,-30,-21},     x:-1,   e0:-125, e1:63,  r0:0,   r1:63};
    tab[4] = '{d:'{1, 1, 1, 1},          x:0,    e0:4,    e1:62,  r0:4,   r1:62};
    tab[5] = '{d:'{-1, 0, 0, 0},         x:0,    e0:-2,   e1:62,  r0:0,   r1:62};
    tab[6] = '{d:'{0, 0, 0, 0},          x:127,  e0:15,   e1:-1,  r0:15,  r1:0};
    tab[7] = '{d:'{0, 0, 0, 0},          x:-128, e0:-16,  e1:126, r0:0,   r1:126};
    none = tab[0];

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Table vectors, back-to-back then with gaps
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 8; i++) begin
        for (int c = 0; c < IN_CH; c++)
          for (int j = 0; j < 9; j++) pix[c][j] = tab[i].d[c];
        pix[0][0] = tab[i].d[0] + tab[i].x;
        send_pixel(4'(i + 1), g * 3, 1'b1, tab[i], 1'b0);
      end
    end
    wait_drain();

    // Randomised pixels against the reference model
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) rand_pix(-6, 6);
      else rand_pix(-128, 127);
      send_pixel(4'($urandom), (i % 2) * 3, 1'b0, none, 1'b0);
    end
    wait_drain();

    // Resync: sof on the ch_cnt==2 beat restarts the pixel
    rand_pix(-128, 127);
    send_beats(2);
    rand_pix(-20, 20);
    send_pixel(4'b0010, 0, 1'b0, none, 1'b1);
    rand_pix(-20, 20);
    send_pixel(4'b1000, 1, 1'b0, none, 1'b0);
    wait_drain();

    // Mid-pixel reset: partial pixel must never emerge
    nv = n_valid;
    rand_pix(-128, 127);
    send_beats(2);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    err_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("no_valid_after_reset", n_valid, nv);
    rand_pix(-50, 50);
    send_pixel(4'b1111, 0, 1'b0, none, 1'b0);
    wait_drain();

    check("valid_count", n_valid, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
